// File: rtl/sgpio_led_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sgpio_led_decode
//  Description : Filters SGPIO parallel frames and decodes per-drive
//                activity/locate/fail LEDs with activity stretch and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgpio_led_decode #(
    parameter int IN_BYTE_REGS  = 1,
    parameter int DRIVES        = 2,
    parameter int FILTER_FRAMES = 2,
    parameter int ACT_STRETCH   = 4,
    parameter int FRAME_TIMEOUT = 1024
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iLoad,
    input  logic [8*IN_BYTE_REGS-1:0] iPData,
    output logic [DRIVES-1:0]         oAct,
    output logic [DRIVES-1:0]         oLoc,
    output logic [DRIVES-1:0]         oFail,
    output logic                      oFrameStb,
    output logic                      oMismatch,
    output logic                      oTimeout
);

    localparam int c_W    = 8 * IN_BYTE_REGS;
    localparam int c_VW   = 3 * DRIVES;
    localparam int c_MC_W = $clog2(FILTER_FRAMES + 1);
    localparam int c_ST_W = (ACT_STRETCH > 0) ? $clog2(ACT_STRETCH + 1) : 1;
    localparam int c_TO_W = (FRAME_TIMEOUT > 0) ? $clog2(FRAME_TIMEOUT + 1) : 1;
    localparam logic [c_MC_W-1:0] c_FILT    = c_MC_W'(FILTER_FRAMES);
    localparam logic [c_ST_W-1:0] c_STRETCH = c_ST_W'(ACT_STRETCH);

    typedef enum logic [0:0] {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                r_loadDly;
    logic                r_sampleStb;
    logic                w_frameEvt;
    logic [DRIVES-1:0]   w_act;
    logic [DRIVES-1:0]   w_loc;
    logic [DRIVES-1:0]   w_fail;
    logic [c_VW-1:0]     w_vec;
    logic [c_VW-1:0]     r_cand;
    logic [c_MC_W-1:0]   r_matchCnt;
    logic [c_MC_W-1:0]   w_matchNext;
    logic                w_same;
    logic                w_commit;
    logic                w_toExpire;
    logic [DRIVES-1:0]   r_act;
    logic [DRIVES-1:0]   r_loc;
    logic [DRIVES-1:0]   r_fail;
    logic [c_ST_W-1:0]   r_stretch [DRIVES];
    logic                r_frameStb;
    logic                r_mismatch;
    logic                r_timeout;
    logic                w_unused;

    // Bits past the decoded drives carry no meaning for this block.
    assign w_unused = ^iPData;

    assign w_frameEvt = ~iLoad & r_loadDly;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_loadDly   <= 1'b1;
            r_sampleStb <= 1'b0;
        end else begin
            r_loadDly   <= iLoad;
            r_sampleStb <= w_frameEvt;
        end
    end

    // Drive d occupies three bits counted down from the MSB: act, loc, fail.
    for (genvar d = 0; d < DRIVES; d++) begin : g_field
        assign w_act[d]          = iPData[c_W-1-3*d];
        assign w_loc[d]          = iPData[c_W-2-3*d];
        assign w_fail[d]         = iPData[c_W-3-3*d];
        assign w_vec[3*d +: 3]   = {w_act[d], w_loc[d], w_fail[d]};
    end

    assign w_same      = (w_vec == r_cand);
    assign w_matchNext = !w_same ? c_MC_W'(1) :
                         (r_matchCnt == c_FILT) ? c_FILT : r_matchCnt + 1'b1;
    assign w_commit    = r_sampleStb && (w_matchNext == c_FILT);

    if (FRAME_TIMEOUT != 0) begin : g_timeout
        localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(FRAME_TIMEOUT - 1);
        logic [c_TO_W-1:0] r_toCnt;
        logic              r_toHold;

        // A sample in the expiry cycle takes priority over the timeout.
        assign w_toExpire = !r_sampleStb && !r_toHold && (r_toCnt == c_TO_LAST);

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                r_toCnt  <= '0;
                r_toHold <= 1'b0;
            end else if (r_sampleStb) begin
                r_toCnt  <= '0;
                r_toHold <= 1'b0;
            end else if (w_toExpire) begin
                r_toCnt  <= '0;
                r_toHold <= 1'b1;
            end else if (!r_toHold) begin
                r_toCnt  <= r_toCnt + 1'b1;
            end
        end
    end else begin : g_noTimeout
        assign w_toExpire = 1'b0;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_cand     <= '0;
            r_matchCnt <= '0;
            r_loc      <= '0;
            r_fail     <= '0;
            r_frameStb <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_frameStb <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= w_toExpire;
            if (r_sampleStb) begin
                r_cand     <= w_vec;
                r_matchCnt <= w_matchNext;
                r_mismatch <= ~w_same;
                if (w_commit) begin
                    r_loc      <= w_loc;
                    r_fail     <= w_fail;
                    r_frameStb <= 1'b1;
                end
            end else if (w_toExpire) begin
                r_cand     <= '0;
                r_matchCnt <= '0;
                r_loc      <= '0;
                r_fail     <= '0;
            end
        end
    end

    // The LED stays lit while the pre-commit stretch count is nonzero, so it
    // holds for ACT_STRETCH commits after the activity bit clears.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_act <= '0;
            for (int d = 0; d < DRIVES; d++) begin
                r_stretch[d] <= '0;
            end
        end else if (w_commit) begin
            for (int d = 0; d < DRIVES; d++) begin
                r_act[d] <= w_act[d] | (r_stretch[d] != '0);
                if (w_act[d]) begin
                    r_stretch[d] <= c_STRETCH;
                end else if (r_stretch[d] != '0) begin
                    r_stretch[d] <= r_stretch[d] - 1'b1;
                end
            end
        end else if (w_toExpire) begin
            r_act <= '0;
            for (int d = 0; d < DRIVES; d++) begin
                r_stretch[d] <= '0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (w_commit) begin
            w_stateNext = ACTIVE;
        end else if (w_toExpire) begin
            w_stateNext = SYNC;
        end
    end

    assign oAct      = r_act;
    assign oLoc      = r_loc;
    assign oFail     = r_fail;
    assign oFrameStb = r_frameStb;
    assign oMismatch = r_mismatch;
    assign oTimeout  = r_timeout;

endmodule
`default_nettype wire
